// File: rtl/pld_led_status.sv
// pld_led_status: heartbeat passthrough LED driver that plays posted status
// codes as N blinks followed by a dark gap, with PWM dimming on every lit cycle.
module pld_led_status #(
  parameter int unsigned PWM_WIDTH  = 8,
  parameter int unsigned CODE_WIDTH = 4,
  parameter int unsigned GAP_TICKS  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  hb_in,
  input  logic                  code_valid,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  code_ready,
  input  logic [PWM_WIDTH-1:0]  brightness,
  output logic                  led_out
);

  localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_ON   = 3'd2,
    S_OFF  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_hb_q;
  logic [PWM_WIDTH-1:0]  r_pwm_cnt;
  logic [CODE_WIDTH-1:0] r_rem;
  logic [GAP_W-1:0]      r_gap;

  logic w_tick;
  logic w_pwm_on;

  // Both heartbeat edges act as the slow timebase tick.
  assign w_tick   = (hb_in != r_hb_q);
  assign w_pwm_on = (r_pwm_cnt < brightness);

  // Heartbeat edge detector and free-running PWM counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hb_q    <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_hb_q    <= hb_in;
      r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
    end
  end

  // Blink-code sequencer; led_out registers the LED value of the current state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_gap      <= '0;
      led_out    <= 1'b0;
      code_ready <= 1'b0;
    end else begin
      led_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          led_out <= hb_in & w_pwm_on;
          if (code_valid && code_ready) begin
            r_rem      <= code;
            r_state    <= S_SYNC;
            code_ready <= 1'b0;
          end else begin
            code_ready <= 1'b1;
          end
        end
        S_SYNC: begin
          if (w_tick) begin
            if (r_rem == '0) begin
              r_gap   <= GAP_W'(GAP_TICKS);
              r_state <= S_GAP;
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_ON: begin
          led_out <= w_pwm_on;
          if (w_tick) begin
            r_rem   <= r_rem - CODE_WIDTH'(1);
            r_state <= S_OFF;
          end
        end
        S_OFF: begin
          if (w_tick) begin
            if (r_rem == '0) begin
              r_gap   <= GAP_W'(GAP_TICKS);
              r_state <= S_GAP;
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            // Counter is held at zero rather than wrapping.
            if (r_gap != '0) begin
              r_gap <= r_gap - GAP_W'(1);
            end
            if (r_gap <= GAP_W'(1)) begin
              r_state    <= S_IDLE;
              code_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          code_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pld_led_status.sv
// Self-checking bench for pld_led_status: directed scenarios plus randomized
// codes, checked every cycle against a tick-timeline reference model.
module tb_pld_led_status;

  localparam int PW = 8;
  localparam int CW = 4;
  localparam int GT = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          hb_in;
  logic          code_valid;
  logic [CW-1:0] code;
  logic [PW-1:0] brightness;
  logic          code_ready;
  logic          led_out;

  pld_led_status #(.PWM_WIDTH(PW), .CODE_WIDTH(CW), .GAP_TICKS(GT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .hb_in      (hb_in),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .brightness (brightness),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an accepted code is a timeline of ticks since accept.
  // Tick 0 is the sync wait, ticks 1..2N alternate lit/dark, then GT dark ticks.
  int m_pwm;
  bit m_hbq, m_busy, m_ready, exp_led;
  int m_n, m_k;
  bit last_tick;
  bit hb_run;
  int half, hcnt;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict outputs from current inputs, clock, compare, advance heartbeat.
  task automatic step();
    bit pon, lit;
    if (!resetn) begin
      exp_led = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
      m_pwm = 0; m_hbq = 1'b0; last_tick = 1'b0;
    end else begin
      last_tick = (hb_in != m_hbq);
      pon = (m_pwm < int'(brightness));
      if (!m_busy) begin
        exp_led = hb_in & pon;
        if (code_valid && m_ready) begin
          m_busy = 1'b1; m_n = int'(code); m_k = 0; m_ready = 1'b0;
        end else begin
          m_ready = 1'b1;
        end
      end else begin
        lit = (m_k >= 1) && (m_k < 1 + 2*m_n) && (((m_k - 1) % 2) == 0);
        exp_led = lit & pon;
        if (last_tick) begin
          m_k++;
          if (m_k == 1 + 2*m_n + GT) begin
            m_busy = 1'b0; m_ready = 1'b1;
          end
        end
      end
      m_hbq = hb_in;
      m_pwm = (m_pwm + 1) % (1 << PW);
    end
    @(posedge clk); #1;
    chk("led_out", led_out, exp_led);
    chk("code_ready", code_ready, m_ready);
    if (hb_run) begin
      hcnt++;
      if (hcnt >= half) begin hcnt = 0; hb_in = ~hb_in; end
    end
  endtask

  // Offer a code for one cycle once ready; optionally align the accept with a tick.
  task automatic post_code(input int c, input bit with_tick);
    int guard = 0;
    while (!(m_ready && (!with_tick || hcnt == 0)) && guard < 2000) begin
      step(); guard++;
    end
    code = CW'(c);
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    code = CW'($urandom);
  endtask

  // Count DUT-visible ticks from the accept until code_ready returns.
  task automatic run_to_idle(input string tag, input int n, input bit poke_busy);
    int ticks = 0;
    int guard = 0;
    bit poked = 1'b0;
    while (code_ready !== 1'b1 && guard < 5000) begin
      if (poke_busy && !poked && m_busy && m_k == 1) begin
        code = CW'(5); code_valid = 1'b1; poked = 1'b1;
      end
      step();
      code_valid = 1'b0;
      if (last_tick) ticks++;
      guard++;
    end
    chk_int(tag, ticks, 1 + 2*n + GT);
  endtask

  initial begin
    int lit_cnt;
    int guard;
    resetn = 1'b0; hb_in = 1'b0; code_valid = 1'b0; code = '0; brightness = 8'd128;
    hb_run = 1'b1; half = 3; hcnt = 0;
    m_pwm = 0; m_hbq = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_n = 0; m_k = 0;

    // Reset held with heartbeat toggling.
    repeat (12) step();
    chk("rst_led", led_out, 1'b0);
    chk("rst_ready", code_ready, 1'b0);
    hb_run = 1'b0; hb_in = 1'b0;
    resetn = 1'b1;
    step();
    chk("ready_after_release", code_ready, 1'b1);

    // Idle passthrough: 50% duty with heartbeat high, dark with heartbeat low.
    hb_in = 1'b1;
    step();
    lit_cnt = 0;
    repeat (256) begin step(); if (led_out === 1'b1) lit_cnt++; end
    chk_int("duty128", lit_cnt, 128);
    hb_in = 1'b0;
    step();
    lit_cnt = 0;
    repeat (256) begin step(); if (led_out === 1'b1) lit_cnt++; end
    chk_int("hb_low_dark", lit_cnt, 0);

    // Code 3 at full brightness, then code 0.
    brightness = 8'd255; hb_run = 1'b1; half = 8; hcnt = 0;
    post_code(3, 1'b0);
    run_to_idle("code3_ticks", 3, 1'b0);
    post_code(0, 1'b0);
    run_to_idle("code0_ticks", 0, 1'b0);

    // Busy offer of code 5 during ON is dropped; accept aligned with a tick.
    post_code(3, 1'b0);
    run_to_idle("busy_ignored", 3, 1'b1);
    post_code(2, 1'b1);
    run_to_idle("accept_on_tick", 2, 1'b0);

    // Randomized codes, brightness and heartbeat rate.
    for (int i = 0; i < 8; i++) begin
      int c;
      brightness = PW'($urandom);
      half = int'($urandom_range(2, 12));
      c = int'($urandom_range(0, (1 << CW) - 1));
      post_code(c, 1'($urandom_range(0, 1)));
      run_to_idle("rand_ticks", c, 1'($urandom_range(0, 1)));
    end

    // Mid-sequence reset while in OFF with two blinks remaining.
    brightness = 8'd200; half = 6;
    post_code(3, 1'b0);
    guard = 0;
    while (!(m_busy && m_k == 2) && guard < 2000) begin step(); guard++; end
    chk_int("reach_off_rem2", m_k, 2);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_led", led_out, 1'b0);
    chk("midrst_ready", code_ready, 1'b0);
    hb_run = 1'b0; hb_in = 1'b0;
    @(negedge clk);
    step();
    resetn = 1'b1;
    step();
    chk("midrst_ready_back", code_ready, 1'b1);
    lit_cnt = 0;
    repeat (200) begin step(); if (led_out === 1'b1) lit_cnt++; end
    chk_int("no_residual_blinks", lit_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pld_led_status.md
# pld_led_status

Blink-code status LED driver, the stage directly downstream of the heartbeat counter. It consumes the heartbeat square wave and uses each of its edges as a slow timebase tick. When idle, it passes the heartbeat through to the LED. When another block posts a status code, it plays the code as a sequence of N blinks followed by a dark gap, then returns to heartbeat mode. All LED output is PWM-dimmed by a runtime brightness value.

## Interface
- `PWM_WIDTH`, default 8: width of the brightness input and the PWM counter.
- `CODE_WIDTH`, default 4: width of the status code. Maximum blink count is 2^CODE_WIDTH−1.
- `GAP_TICKS`, default 4: number of ticks the LED stays dark after a code, before heartbeat mode resumes. Must be ≥ 1.
- `clk` in 1: system clock. Same domain as the heartbeat source.
- `resetn` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `hb_in` in 1: heartbeat square wave, synchronous to `clk`.
- `code_valid` in 1: a status code is offered.
- `code` in CODE_WIDTH: number of blinks to play.
- `code_ready` out 1: block can accept a code. Registered.
- `brightness` in PWM_WIDTH: LED duty, equal to brightness/2^PWM_WIDTH. 0 = dark.
- `led_out` out 1: LED drive. Registered.

## Operation
- **Tick.** `hb_in` is registered once into `hb_q`. The tick is `hb_in != hb_q`, i.e. a one-cycle pulse on both edges of the heartbeat.
- **PWM.** A free-running PWM_WIDTH counter wraps at 2^PWM_WIDTH−1 → 0. `pwm_on = pwm_cnt < brightness`, so brightness 0 is never lit. `brightness` is sampled every cycle, with no latching.
- **States:** IDLE, SYNC, ON, OFF, GAP. There is a blink-remaining counter `rem` (CODE_WIDTH bits) and a gap counter.
- **IDLE:**
  - LED value is `hb_in & pwm_on`.
  - On `code_valid & code_ready`: latch `code` into `rem` and go to SYNC.
  - A tick in the same cycle as the accept is not consumed.
- **SYNC:**
  - LED dark.
  - On tick: if `rem == 0`, go to GAP and load the gap counter with GAP_TICKS. Otherwise go to ON.
- **ON:**
  - LED value is `pwm_on`.
  - On tick: decrement `rem` and go to OFF.
- **OFF:**
  - LED dark.
  - On tick: if `rem == 0`, go to GAP and load GAP_TICKS. Otherwise go to ON.
- **GAP:**
  - LED dark.
  - Decrement the gap counter on each tick. On the tick that brings it to 0, go to IDLE.
- **Handshake.**
  - `code_ready` is 1 only while the state is IDLE.
  - `code_valid` in any other state is ignored and not queued.
  - The source must hold `code` stable until the accept cycle.
- **Code 0.** Accepted; produces no blinks. Sequence is SYNC, then GAP, then IDLE.
- **Reset.** Asserting `resetn` at any time, including mid-sequence, immediately forces:
  - state = IDLE, `rem` = 0, gap counter = 0, `pwm_cnt` = 0, `hb_q` = 0;
  - `led_out` = 0, `code_ready` = 0.

## Timing
- **Reset values.** `led_out` = 0 and `code_ready` = 0. `code_ready` rises to 1 on the first `clk` edge after `resetn` is released.
- **LED latency.** `led_out` is the registered next-LED value, so it lags `hb_in` and `pwm_cnt` by one cycle. The state transition and `led_out` update on the same edge.
- **Handshake timing.** `code_ready` is registered from the next-state value. It falls on the edge that accepts a code, so the cycle after an accept shows `code_ready` = 0. It rises on the edge that enters IDLE.
- **Tick timing.** A tick occurs the cycle after an `hb_in` transition. The sequence length for code N ≥ 1 is 1 + 2N + GAP_TICKS ticks after the accept, counting the SYNC wait.
- **Wrap.** `pwm_cnt` wraps silently. `rem` and the gap counter never underflow, because transitions are taken at 0.

## Test plan
- **Reset release.** Hold `resetn` = 0 with `hb_in` toggling → `led_out` = 0 and `code_ready` = 0. Release reset → `code_ready` = 1 one cycle later.
- **Idle passthrough.** brightness = 128, `hb_in` held at 1 → `led_out` high for exactly 128 of every 256 cycles. Set `hb_in` = 0 → `led_out` stays 0.
- **Code 3, GAP_TICKS = 4, brightness = 255.**
  - Accept code 3 → exactly 3 lit ON windows, each one tick long, separated by dark OFF ticks.
  - Then 4 dark ticks, then return to IDLE with `code_ready` = 1.
  - `code_ready` = 0 throughout the sequence.
- **Code 0.** Accept code 0 → no lit cycles, SYNC followed by 4 GAP ticks, then IDLE.
- **Busy and simultaneous events.** Pulse `code_valid` with code 5 while in state ON → ignored; the original blink count completes. Accept a code in the same cycle as a tick → that tick is not consumed; the first ON begins on the following tick.
- **Mid-sequence reset.** Assert `resetn` during OFF with `rem` = 2 → `led_out` = 0 immediately. After release, the block is in IDLE with `code_ready` = 1 one cycle later, and no residual blinks follow.
